// File: rtl/mem_port_arbiter_if.sv
// Bundle of the pipeline-side and bus-side signals of the memory port arbiter.
// The slave modport is the arbiter's view; master is the view of the pipeline
// and memory model that surround it.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Instruction fetch side
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_valid;
  // Load/store side
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_done;
  // Pipeline freeze controls
  logic                  stall_if;
  logic                  stall_mem;
  // Unified memory bus
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [DATA_WIDTH-1:0] bus_rdata;
  logic                  bus_ack;
  // Sticky bus timeout flag
  logic                  err;

  modport slave (
    input  if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata,
    input  bus_rdata, bus_ack,
    output if_rdata, if_valid, mem_rdata, mem_done, stall_if, stall_mem,
    output bus_req, bus_we, bus_addr, bus_wdata, err
  );

  modport master (
    output if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata,
    output bus_rdata, bus_ack,
    input  if_rdata, if_valid, mem_rdata, mem_done, stall_if, stall_mem,
    input  bus_req, bus_we, bus_addr, bus_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and load/store.
// Data accesses win over fetches; each access is a req/ack transaction that
// ends in a one-cycle done pulse. A hung bus is aborted after TIMEOUT cycles
// without ack, raising a sticky err and returning zero data.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15,
  parameter int TO_WIDTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  p
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_WAIT = 3'd1,
    I_WAIT = 3'd2,
    D_DONE = 3'd3,
    I_DONE = 3'd4
  } state_t;

  state_t                state_q,     state_d;
  logic                  bus_req_q,   bus_req_d;
  logic                  bus_we_q,    bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q,  bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
  logic                  if_valid_q,  if_valid_d;
  logic                  mem_done_q,  mem_done_d;
  logic                  err_q,       err_d;
  logic [TO_WIDTH-1:0]   to_cnt_q,    to_cnt_d;

  // Value the wait counter would take this cycle; reaching TIMEOUT means
  // TIMEOUT consecutive ack-less cycles have elapsed and the access is aborted.
  logic [TO_WIDTH-1:0]   to_cnt_inc;
  logic                  timeout_hit;

  // Next-state, bus sequencing, data capture and timeout handling
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_valid_d  = 1'b0;
    mem_done_d  = 1'b0;
    err_d       = err_q;
    to_cnt_d    = to_cnt_q;
    to_cnt_inc  = to_cnt_q + TO_WIDTH'(1);
    timeout_hit = (to_cnt_inc == TO_WIDTH'(TIMEOUT));

    case (state_q)
      IDLE: begin
        if (p.mem_read || p.mem_write) begin
          // Data beats fetch; a simultaneous read+write is treated as a write.
          bus_addr_d  = p.mem_addr;
          bus_wdata_d = p.mem_wdata;
          bus_we_d    = p.mem_write;
          bus_req_d   = 1'b1;
          to_cnt_d    = '0;
          state_d     = D_WAIT;
        end else if (p.if_req) begin
          bus_addr_d  = p.if_addr;
          bus_we_d    = 1'b0;
          bus_req_d   = 1'b1;
          to_cnt_d    = '0;
          state_d     = I_WAIT;
        end
      end

      D_WAIT: begin
        if (p.bus_ack) begin
          bus_req_d  = 1'b0;
          if (!bus_we_q) mem_rdata_d = p.bus_rdata;
          to_cnt_d   = '0;
          mem_done_d = 1'b1;
          state_d    = D_DONE;
        end else if (timeout_hit) begin
          bus_req_d  = 1'b0;
          err_d      = 1'b1;
          if (!bus_we_q) mem_rdata_d = '0;
          to_cnt_d   = '0;
          mem_done_d = 1'b1;
          state_d    = D_DONE;
        end else begin
          to_cnt_d   = to_cnt_inc;
        end
      end

      I_WAIT: begin
        if (p.bus_ack) begin
          bus_req_d  = 1'b0;
          if_rdata_d = p.bus_rdata;
          to_cnt_d   = '0;
          if_valid_d = 1'b1;
          state_d    = I_DONE;
        end else if (timeout_hit) begin
          bus_req_d  = 1'b0;
          err_d      = 1'b1;
          if_rdata_d = '0;
          to_cnt_d   = '0;
          if_valid_d = 1'b1;
          state_d    = I_DONE;
        end else begin
          to_cnt_d   = to_cnt_inc;
        end
      end

      // The done cycle never re-grants: the requester is still holding its
      // request this cycle and must not be served twice.
      D_DONE:  state_d = IDLE;
      I_DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_done_q  <= 1'b0;
      err_q       <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_valid_q  <= if_valid_d;
      mem_done_q  <= mem_done_d;
      err_q       <= err_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign p.bus_req   = bus_req_q;
  assign p.bus_we    = bus_we_q;
  assign p.bus_addr  = bus_addr_q;
  assign p.bus_wdata = bus_wdata_q;
  assign p.if_rdata  = if_rdata_q;
  assign p.if_valid  = if_valid_q;
  assign p.mem_rdata = mem_rdata_q;
  assign p.mem_done  = mem_done_q;
  assign p.err       = err_q;

  // Stalls follow the live requests so the pipeline freezes the same cycle
  assign p.stall_if  = p.if_req && !if_valid_q;
  assign p.stall_mem = (p.mem_read || p.mem_write) && !mem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table covers the
// single-cycle behaviours, hand-written sequences cover timeout and reset.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO), .TO_WIDTH(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .p     (bif)
  );

  typedef struct {
    logic        mr, mw, ir;
    logic [31:0] ma, md, ia;
    logic        ack;
    logic [31:0] rd;
    logic        e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic        e_mdone;
    logic [31:0] e_mrdata;
    logic        e_ival;
    logic [31:0] e_irdata;
    logic        e_sif, e_smem, e_err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    logic mr, logic mw, logic ir, logic [31:0] ma, logic [31:0] md, logic [31:0] ia,
    logic ack, logic [31:0] rd,
    logic req, logic we, logic [31:0] addr, logic [31:0] wdata,
    logic mdone, logic [31:0] mrdata, logic ival, logic [31:0] irdata,
    logic sif, logic smem, logic err);
    vec_t v;
    v.mr = mr; v.mw = mw; v.ir = ir; v.ma = ma; v.md = md; v.ia = ia;
    v.ack = ack; v.rd = rd;
    v.e_req = req; v.e_we = we; v.e_addr = addr; v.e_wdata = wdata;
    v.e_mdone = mdone; v.e_mrdata = mrdata; v.e_ival = ival; v.e_irdata = irdata;
    v.e_sif = sif; v.e_smem = smem; v.e_err = err;
    return v;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%08h, want 0x%08h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(logic mr, logic mw, logic ir, logic [31:0] ma, logic [31:0] md,
                       logic [31:0] ia, logic ack, logic [31:0] rd);
    bif.mem_read  = mr;
    bif.mem_write = mw;
    bif.if_req    = ir;
    bif.mem_addr  = ma;
    bif.mem_wdata = md;
    bif.if_addr   = ia;
    bif.bus_ack   = ack;
    bif.bus_rdata = rd;
  endtask

  task automatic check_vec(int i, vec_t v);
    chk("bus_req",   i, 32'(bif.bus_req),   32'(v.e_req));
    chk("bus_we",    i, 32'(bif.bus_we),    32'(v.e_we));
    chk("bus_addr",  i, bif.bus_addr,       v.e_addr);
    chk("bus_wdata", i, bif.bus_wdata,      v.e_wdata);
    chk("mem_done",  i, 32'(bif.mem_done),  32'(v.e_mdone));
    chk("mem_rdata", i, bif.mem_rdata,      v.e_mrdata);
    chk("if_valid",  i, 32'(bif.if_valid),  32'(v.e_ival));
    chk("if_rdata",  i, bif.if_rdata,       v.e_irdata);
    chk("stall_if",  i, 32'(bif.stall_if),  32'(v.e_sif));
    chk("stall_mem", i, 32'(bif.stall_mem), 32'(v.e_smem));
    chk("err",       i, 32'(bif.err),       32'(v.e_err));
  endtask

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // Stimulus and checking
  initial begin
    int hi_cycles;
    bit dropped;
    // Columns: mr mw ir ma md ia ack rd | req we addr wdata mdone mrdata ival irdata sif smem err
    // Reset state / idle
    vq.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0,0));
    // Zero-wait load at 0x40
    vq.push_back(mk(1,0,0, 32'h40,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,1,0));
    vq.push_back(mk(1,0,0, 32'h40,0,0, 1,32'hDEADBEEF, 1,0,32'h40,0, 0,0, 0,0, 0,1,0));
    vq.push_back(mk(1,0,0, 32'h40,0,0, 0,0, 0,0,32'h40,0, 1,32'hDEADBEEF, 0,0, 0,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,32'h40,0, 0,32'hDEADBEEF, 0,0, 0,0,0));
    // Store 0x12345678 to 0x80 with three wait states; ack data must be ignored
    vq.push_back(mk(0,1,0, 32'h80,32'h12345678,0, 0,0, 0,0,32'h40,0, 0,32'hDEADBEEF, 0,0, 0,1,0));
    for (int k = 0; k < 3; k++)
      vq.push_back(mk(0,1,0, 32'h80,32'h12345678,0, 0,0, 1,1,32'h80,32'h12345678, 0,32'hDEADBEEF, 0,0, 0,1,0));
    vq.push_back(mk(0,1,0, 32'h80,32'h12345678,0, 1,32'hCAFEF00D, 1,1,32'h80,32'h12345678, 0,32'hDEADBEEF, 0,0, 0,1,0));
    vq.push_back(mk(0,1,0, 32'h80,32'h12345678,0, 0,0, 0,1,32'h80,32'h12345678, 1,32'hDEADBEEF, 0,0, 0,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0, 0,1,32'h80,32'h12345678, 0,32'hDEADBEEF, 0,0, 0,0,0));
    // Conflict: fetch 0x0 and load 0x100 together; data goes first
    vq.push_back(mk(1,0,1, 32'h100,0,0, 0,0, 0,1,32'h80,32'h12345678, 0,32'hDEADBEEF, 0,0, 1,1,0));
    vq.push_back(mk(1,0,1, 32'h100,0,0, 1,32'h11111111, 1,0,32'h100,0, 0,32'hDEADBEEF, 0,0, 1,1,0));
    vq.push_back(mk(1,0,1, 32'h100,0,0, 0,0, 0,0,32'h100,0, 1,32'h11111111, 0,0, 1,0,0));
    vq.push_back(mk(0,0,1, 0,0,0, 0,0, 0,0,32'h100,0, 0,32'h11111111, 0,0, 1,0,0));
    vq.push_back(mk(0,0,1, 0,0,0, 0,0, 1,0,0,0, 0,32'h11111111, 0,0, 1,0,0));
    vq.push_back(mk(0,0,1, 0,0,0, 1,32'h87654321, 1,0,0,0, 0,32'h11111111, 0,0, 1,0,0));
    vq.push_back(mk(0,0,1, 0,0,0, 0,0, 0,0,0,0, 0,32'h11111111, 1,32'h87654321, 0,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,32'h11111111, 0,32'h87654321, 0,0,0));
    // Illegal read+write: the write wins and mem_rdata is untouched
    vq.push_back(mk(1,1,0, 32'h200,32'hA5A5A5A5,0, 0,0, 0,0,0,0, 0,32'h11111111, 0,32'h87654321, 0,1,0));
    vq.push_back(mk(1,1,0, 32'h200,32'hA5A5A5A5,0, 1,32'h22222222, 1,1,32'h200,32'hA5A5A5A5, 0,32'h11111111, 0,32'h87654321, 0,1,0));
    vq.push_back(mk(1,1,0, 32'h200,32'hA5A5A5A5,0, 0,0, 0,1,32'h200,32'hA5A5A5A5, 1,32'h11111111, 0,32'h87654321, 0,0,0));
    // Stray ack while idle: nothing happens
    vq.push_back(mk(0,0,0, 0,0,0, 1,32'h33333333, 0,1,32'h200,32'hA5A5A5A5, 0,32'h11111111, 0,32'h87654321, 0,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0, 0,1,32'h200,32'hA5A5A5A5, 0,32'h11111111, 0,32'h87654321, 0,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0, 0,1,32'h200,32'hA5A5A5A5, 0,32'h11111111, 0,32'h87654321, 0,0,0));

    drive(0,0,0, 0,0,0, 0,0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: inputs set at the falling edge, outputs checked just after
    for (int i = 0; i < vq.size(); i++) begin
      if (i > 0) @(negedge clk);
      drive(vq[i].mr, vq[i].mw, vq[i].ir, vq[i].ma, vq[i].md, vq[i].ia, vq[i].ack, vq[i].rd);
      #1;
      check_vec(i, vq[i]);
      $display("vec %0d: req=%0b we=%0b addr=%08h mdone=%0b ival=%0b err=%0b",
               i, bif.bus_req, bif.bus_we, bif.bus_addr, bif.mem_done, bif.if_valid, bif.err);
    end

    // Timeout: fetch at 0x300 on a bus that never acks
    @(negedge clk);
    drive(0,0,1, 0,0,32'h300, 0,0);
    #1;
    chk("to_req_idle", 0, 32'(bif.bus_req), 32'd0);
    hi_cycles = 0;
    dropped = 1'b0;
    for (int c = 0; c < 40 && !dropped; c++) begin
      @(negedge clk);
      #1;
      if (bif.bus_req) hi_cycles++;
      else dropped = 1'b1;
    end
    chk("to_dropped", 0, 32'(dropped), 32'd1);
    chk("to_req_cycles", 0, hi_cycles, TO);
    chk("to_if_valid", 0, 32'(bif.if_valid), 32'd1);
    chk("to_if_rdata", 0, bif.if_rdata, 32'd0);
    chk("to_err", 0, 32'(bif.err), 32'd1);
    chk("to_bus_addr", 0, bif.bus_addr, 32'h300);
    $display("timeout: bus_req high %0d cycles, err=%0b if_rdata=%08h", hi_cycles, bif.err, bif.if_rdata);
    bif.if_req = 1'b0;
    @(negedge clk);
    #1;
    chk("to_if_valid_off", 0, 32'(bif.if_valid), 32'd0);
    chk("to_err_sticky", 0, 32'(bif.err), 32'd1);

    // Load after the timeout still completes and err stays set
    drive(1,0,0, 32'h400,0,0, 0,0);
    @(negedge clk);
    bif.bus_ack = 1'b1;
    bif.bus_rdata = 32'h44444444;
    #1;
    chk("post_to_req", 0, 32'(bif.bus_req), 32'd1);
    @(negedge clk);
    bif.bus_ack = 1'b0;
    #1;
    chk("post_to_done", 0, 32'(bif.mem_done), 32'd1);
    chk("post_to_rdata", 0, bif.mem_rdata, 32'h44444444);
    chk("post_to_err", 0, 32'(bif.err), 32'd1);
    $display("post-timeout load: mem_done=%0b mem_rdata=%08h err=%0b", bif.mem_done, bif.mem_rdata, bif.err);
    bif.mem_read = 1'b0;
    @(negedge clk);

    // Reset during D_WAIT drops bus_req before any clock edge; held load reissues
    drive(1,0,0, 32'h500,0,0, 0,0);
    @(negedge clk);
    #1;
    chk("rst_req_before", 0, 32'(bif.bus_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_req_async", 0, 32'(bif.bus_req), 32'd0);
    chk("rst_err_clear", 0, 32'(bif.err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_idle_req", 0, 32'(bif.bus_req), 32'd0);
    chk("rst_idle_rdata", 0, bif.mem_rdata, 32'd0);
    @(negedge clk);
    bif.bus_ack = 1'b1;
    bif.bus_rdata = 32'h55555555;
    #1;
    chk("reissue_req", 0, 32'(bif.bus_req), 32'd1);
    chk("reissue_addr", 0, bif.bus_addr, 32'h500);
    chk("reissue_we", 0, 32'(bif.bus_we), 32'd0);
    @(negedge clk);
    bif.bus_ack = 1'b0;
    #1;
    chk("reissue_done", 0, 32'(bif.mem_done), 32'd1);
    chk("reissue_rdata", 0, bif.mem_rdata, 32'h55555555);
    $display("reset reissue: mem_done=%0b mem_rdata=%08h", bif.mem_done, bif.mem_rdata);
    bif.mem_read = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
